fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: burst size encodings,
// burst-length decode, FSM state type and the default boot address.
package fetch_unit_pkg;

    localparam logic [1:0]  SIZE_1  = 2'b00;
    localparam logic [1:0]  SIZE_4  = 2'b01;
    localparam logic [1:0]  SIZE_8  = 2'b10;
    localparam logic [1:0]  SIZE_16 = 2'b11;

    localparam logic [31:0] START_PC_DEFAULT = 32'h8002_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RECV  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    function automatic logic [4:0] burst_len(input logic [1:0] size);
        case (size)
            SIZE_1:  burst_len = 5'd1;
            SIZE_4:  burst_len = 5'd4;
            SIZE_8:  burst_len = 5'd8;
            SIZE_16: burst_len = 5'd16;
            default: burst_len = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO with flush. The head reads as zero while
// empty so nothing stale can leak out after a flush or reset.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so push is allowed when full.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign head  = empty ? '0 : mem[rd_ptr];

    // Storage array, no reset needed: validity is carried by count.
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; flush dominates any push or pop.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues fixed-size read bursts, buffers returned
// words with their pcs, and handles redirects by flushing and draining.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] START_PC    = START_PC_DEFAULT,
    parameter logic [1:0]  ACCESS_SIZE = SIZE_4,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic [1:0]  mem_access_size,
    output logic        mem_rw,
    output logic        mem_enable,
    input  logic        mem_busy,
    input  logic [31:0] mem_data_out,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        insn_valid,
    input  logic        insn_ready
);
    localparam logic [4:0] BURST_N = burst_len(ACCESS_SIZE);
    localparam int         CW      = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  next_state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;
    logic [3:0]    beat_cnt;
    logic          armed;
    logic          accept;
    logic          last_beat;
    logic          pop;
    logic          push;
    logic          fits_now;
    logic          fits_after;
    logic [31:0]   free_now;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [63:0]   fifo_head;
    logic [63:0]   push_data;

    // Free slots exclude nothing in flight here: requests are only raised
    // from IDLE or at the final beat, when no other words are outstanding.
    always_comb begin
        accept     = (state == ST_REQ) && !mem_busy;
        last_beat  = ({1'b0, beat_cnt} == (BURST_N - 5'd1));
        pop        = !fifo_empty && insn_ready && !redirect;
        push       = (state == ST_RECV) && (!fifo_full || pop);
        free_now   = 32'(FIFO_DEPTH) - 32'(fifo_count);
        fits_now   = armed && (free_now >= 32'(BURST_N));
        fits_after = (free_now + 32'(pop)) >= (32'(BURST_N) + 32'd1);
        push_data  = {req_addr + {26'd0, beat_cnt, 2'b00}, mem_data_out};
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (!redirect && fits_now) next_state = ST_REQ;
                else                       next_state = ST_IDLE;
            end
            ST_REQ: begin
                if (accept)        next_state = redirect ? ST_DRAIN : ST_RECV;
                else if (redirect) next_state = ST_IDLE;
                else               next_state = ST_REQ;
            end
            ST_RECV: begin
                if (redirect)       next_state = last_beat ? ST_IDLE : ST_DRAIN;
                else if (last_beat) next_state = fits_after ? ST_REQ : ST_IDLE;
                else                next_state = ST_RECV;
            end
            ST_DRAIN: begin
                if (last_beat) next_state = ST_IDLE;
                else           next_state = ST_DRAIN;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: the request strobe covers the whole REQ state.
    always_comb begin
        if (state == ST_REQ) mem_enable = 1'b1;
        else                 mem_enable = 1'b0;
    end

    // Fetch pc, burst base address, beat counter and post-reset arming delay.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= START_PC;
            req_addr <= START_PC;
            beat_cnt <= 4'd0;
            armed    <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (redirect)    fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            else if (accept) fetch_pc <= fetch_pc + {25'd0, BURST_N, 2'b00};
            else             fetch_pc <= fetch_pc;
            if (next_state == ST_REQ && state != ST_REQ) req_addr <= fetch_pc;
            else                                         req_addr <= req_addr;
            if (state == ST_RECV || state == ST_DRAIN) beat_cnt <= beat_cnt + 4'd1;
            else                                       beat_cnt <= 4'd0;
        end
    end

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign mem_address     = req_addr;
    assign mem_access_size = ACCESS_SIZE;
    assign mem_rw          = 1'b0;
    assign insn            = fifo_head[31:0];
    assign insn_pc         = fifo_head[63:32];
    assign insn_valid      = !fifo_empty;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// checked against an architectural model of the fetched instruction stream.
module tb_fetch_unit;
    localparam logic [31:0] START = 32'h8002_0000;
    localparam int          N     = 4;

    logic        clock;
    logic        reset;
    logic [31:0] mem_address;
    logic [1:0]  mem_access_size;
    logic        mem_rw;
    logic        mem_enable;
    logic        mem_busy;
    logic [31:0] mem_data_out;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_valid;
    logic        insn_ready;

    logic        reset2;
    logic [31:0] w2_addr, w2_insn, w2_pc, w2_data, w2_rpc;
    logic [1:0]  w2_size;
    logic        w2_rw, w2_en, w2_busy, w2_redir, w2_valid, w2_ready;

    fetch_unit dut (
        .clock(clock), .reset(reset), .mem_address(mem_address),
        .mem_access_size(mem_access_size), .mem_rw(mem_rw), .mem_enable(mem_enable),
        .mem_busy(mem_busy), .mem_data_out(mem_data_out), .redirect(redirect),
        .redirect_pc(redirect_pc), .insn(insn), .insn_pc(insn_pc),
        .insn_valid(insn_valid), .insn_ready(insn_ready)
    );

    fetch_unit #(.START_PC(32'hFFFF_FFF0), .ACCESS_SIZE(2'b01), .FIFO_DEPTH(16)) dut_wrap (
        .clock(clock), .reset(reset2), .mem_address(w2_addr),
        .mem_access_size(w2_size), .mem_rw(w2_rw), .mem_enable(w2_en),
        .mem_busy(w2_busy), .mem_data_out(w2_data), .redirect(w2_redir),
        .redirect_pc(w2_rpc), .insn(w2_insn), .insn_pc(w2_pc),
        .insn_valid(w2_valid), .insn_ready(w2_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    int          beats_left, n_acc, n_pop, since_reset;
    logic [31:0] exp_pc, exp_req, held_addr, acc_addr, beat_addr, key;
    bit          acc_prev, hold_prev, chk_invalid, chk_withdraw;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: one beat per cycle starting the cycle after acceptance.
    task automatic mem_tick();
        if (beats_left > 0) begin
            beat_addr  = beat_addr + 32'd4;
            beats_left = beats_left - 1;
        end
        if (acc_prev) begin
            check_eq("burst_overlap", 32'(beats_left), 32'd0);
            beat_addr  = acc_addr;
            beats_left = N;
        end
        mem_data_out = (beats_left > 0) ? memf(beat_addr) : $urandom();
    endtask

    task automatic step(input bit busy, input bit ready, input bit redir, input logic [31:0] rpc);
        @(negedge clock);
        if (since_reset == 0) check_eq("early_req", 32'(mem_enable), 32'd0);
        since_reset++;
        if (chk_invalid)  check_eq("flush_valid", 32'(insn_valid), 32'd0);
        if (chk_withdraw) check_eq("withdraw_en", 32'(mem_enable), 32'd0);
        chk_invalid  = 1'b0;
        chk_withdraw = 1'b0;
        if (hold_prev) begin
            check_eq("hold_en", 32'(mem_enable), 32'd1);
            check_eq("hold_addr", mem_address, held_addr);
        end else if (mem_enable) begin
            check_eq("req_addr", mem_address, exp_req);
        end
        mem_tick();
        reset = 1'b0; mem_busy = busy; insn_ready = ready;
        redirect = redir; redirect_pc = rpc;
        if (insn_valid && ready && !redir) begin
            check_eq("insn_pc", insn_pc, exp_pc);
            check_eq("insn", insn, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        if (redir) begin
            exp_pc       = rpc & 32'hFFFF_FFFC;
            exp_req      = exp_pc;
            chk_invalid  = 1'b1;
            chk_withdraw = mem_enable;
        end else if (mem_enable && !busy) begin
            exp_req = exp_req + 32'(4 * N);
        end
        acc_prev  = mem_enable && !busy;
        acc_addr  = mem_address;
        if (acc_prev) n_acc++;
        hold_prev = mem_enable && busy && !redir;
        held_addr = mem_address;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clock);
        reset = 1'b1; mem_busy = 1'b0; insn_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'd0; mem_data_out = $urandom();
        repeat (cycles) @(negedge clock);
        check_eq("rst_valid", 32'(insn_valid), 32'd0);
        check_eq("rst_en", 32'(mem_enable), 32'd0);
        check_eq("rst_addr", mem_address, START);
        check_eq("rst_rw", 32'(mem_rw), 32'd0);
        check_eq("rst_insn", insn, 32'd0);
        check_eq("rst_pc", insn_pc, 32'd0);
        check_eq("rst_size", 32'(mem_access_size), 32'd1);
        reset = 1'b0;
        beats_left = 0; acc_prev = 1'b0; hold_prev = 1'b0;
        chk_invalid = 1'b0; chk_withdraw = 1'b0; since_reset = 0;
        exp_pc = START; exp_req = START; n_acc = 0;
    endtask

    task automatic wait_beats(input int target, input string tag);
        int guard = 0;
        while (beats_left != target && guard < 100) begin
            step(1'b0, 1'b1, 1'b0, 32'd0);
            guard++;
        end
        check_eq(tag, 32'(beats_left), 32'(target));
    endtask

    initial begin
        logic [31:0] w2_a0, w2_a1, w2_p4;
        int          nreq, npop2, guard, rpops;

        key = 32'd0; n_pop = 0;
        reset2 = 1'b1; w2_busy = 1'b0; w2_redir = 1'b0; w2_ready = 1'b1;
        w2_data = 32'd0; w2_rpc = 32'd0;
        do_reset(2);

        // Wrap-around instance: second burst starts at address zero.
        reset2 = 1'b0;
        w2_a0 = 32'hDEAD_BEEF; w2_a1 = 32'hDEAD_BEEF; w2_p4 = 32'hDEAD_BEEF;
        nreq = 0; npop2 = 0;
        repeat (40) begin
            @(negedge clock);
            if (w2_en) begin
                if (nreq == 0) w2_a0 = w2_addr;
                if (nreq == 1) w2_a1 = w2_addr;
                nreq++;
            end
            if (w2_valid) begin
                if (npop2 == 4) w2_p4 = w2_pc;
                npop2++;
            end
        end
        check_eq("wrap_req0", w2_a0, 32'hFFFF_FFF0);
        check_eq("wrap_req1", w2_a1, 32'h0000_0000);
        check_eq("wrap_pc4", w2_p4, 32'h0000_0000);

        // Basic streaming with memory returning its own address.
        do_reset(1);
        n_pop = 0;
        repeat (30) step(1'b0, 1'b1, 1'b0, 32'd0);
        check_eq("stream_pops", 32'(n_pop >= 8), 32'd1);

        // Back-pressure: exactly four bursts fill the buffer, then a single pop.
        do_reset(1);
        repeat (60) step(1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("full_bursts", 32'(n_acc), 32'd4);
        check_eq("full_en", 32'(mem_enable), 32'd0);
        check_eq("full_count", 32'(dut.u_fifo.count), 32'd16);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("pop_count", 32'(dut.u_fifo.count), 32'd15);
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("pop_no_req", 32'(n_acc), 32'd4);

        // Memory busy for five cycles of the request.
        do_reset(1);
        guard = 0;
        while (!mem_enable && guard < 50) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            guard++;
        end
        check_eq("busy_req_seen", 32'(mem_enable), 32'd1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'd0);
        check_eq("busy_no_acc", 32'(n_acc), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        check_eq("busy_acc6", 32'(n_acc), 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        check_eq("busy_after_en", 32'(mem_enable), 32'd0);

        // Redirect at beat 1: remaining beats dropped, refetch from aligned pc.
        do_reset(1);
        wait_beats(4, "redir_beat0");
        step(1'b0, 1'b1, 1'b1, 32'h8002_0103);
        check_eq("redir_beat1", 32'(beats_left), 32'd3);
        guard = 0;
        step(1'b0, 1'b1, 1'b0, 32'd0);
        while (!mem_enable && guard < 40) begin
            step(1'b0, 1'b1, 1'b0, 32'd0);
            guard++;
        end
        check_eq("redir_req", mem_address, 32'h8002_0100);
        repeat (12) step(1'b0, 1'b1, 1'b0, 32'd0);

        // Reset during beat 2 of a burst.
        do_reset(1);
        wait_beats(3, "rst_beat1");
        do_reset(1);
        repeat (20) step(1'b0, 1'b1, 1'b0, 32'd0);

        // Random traffic against the instruction-stream model.
        rpops = n_pop;
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 3) begin
                key = $urandom();
                do_reset(1 + r);
            end else begin
                step($urandom_range(0, 3) == 0,
                     $urandom_range(0, 9) < 7,
                     $urandom_range(0, 99) < 2,
                     ($urandom_range(0, 1) == 1) ? (START + 32'($urandom_range(0, 255))) : $urandom());
            end
        end
        check_eq("random_pops", 32'((n_pop - rpops) >= 200), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
